dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder end of the pipeline's data-memory port: the responder for the requests the execute stage issues.
- Accepts the addr/rmask/wmask/wdata request from the pipeline and performs a byte-enabled read or write on an internal word array.
- Returns dmem_rdata/dmem_resp after a programmable latency.
- Serves as the data-side memory for pipeline simulation and as the timing template for the later cache front end.

Parameters:
- LATENCY, 2, cycles from request capture to dmem_resp; legal range 1..15.
- DEPTH_WORDS, 1024, number of 32-bit words in the backing array; power of two.
- BASE_ADDR, 32'h1ECEB000, byte address of word 0; word-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dmem_addr  in  32  byte address; bits [1:0] ignored (requester sends word-aligned).
- dmem_rmask  in  4  read byte lanes; nonzero marks a read request.
- dmem_wmask  in  4  write byte lanes; nonzero marks a write request.
- dmem_wdata  in  32  write data, already lane-positioned.
- dmem_rdata  out  32  read data, valid only while dmem_resp=1.
- dmem_resp  out  1  one-cycle completion pulse for reads and writes.
- busy  out  1  high from the capture cycle until the dmem_resp cycle inclusive.
- err  out  1  sticky protocol/range error flag.

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, dmem_resp=0, dmem_rdata=0, busy=0, err=0. Array contents are not reset.
- A request is present when |dmem_rmask or |dmem_wmask.
- States:
  - IDLE: on a request, capture addr, masks and wdata, load counter with LATENCY-1, and go to WAIT. If LATENCY=1, go directly to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: perform the access, drive dmem_resp=1 for exactly this cycle, then return to IDLE.
- Latency: a request sampled at edge T produces dmem_resp high in cycle T+LATENCY.
- The next request can be accepted in the cycle after RESP, so back-to-back spacing is LATENCY+1.
- Request in the RESP cycle itself: ignored. The requester must not issue until it sees resp.
- Read:
  - Word index = (addr-BASE_ADDR)>>2.
  - dmem_rdata returns the stored bytes on rmask lanes and 0 on the other lanes.
  - Read value is the array contents in the RESP cycle.
- Write:
  - Byte-merge the wmask lanes of the captured wdata into the word at the RESP edge.
  - dmem_rdata=0 for writes.
- Ordering: a read issued after a write's resp returns the written data; there are no hazards, since only one request is outstanding.
- dmem_rdata=0 whenever dmem_resp=0.
- Error conditions, each setting err=1 (cleared only by rst):
  - Request present while busy (WAIT or RESP): request dropped, current transaction unaffected.
  - rmask and wmask both nonzero: still captured and responded to, but treated as a no-op (no write, rdata=0).
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): responds normally with rdata=0; no write occurs.
- Width rules: the address offset is computed as 32-bit unsigned subtraction, so addr<BASE_ADDR wraps and lands out of range.
- Reset mid-transaction: the transaction is abandoned, no resp is issued, and a write in flight is not committed.

Decomposition:
- Shared package (rv32i_types):
  - dmem_resp_state_t enum {IDLE, WAIT, RESP}.
  - dmem_req_t struct {addr, rmask, wmask, wdata}, used for the capture register.
- Sub-module dmem_sram_be: a DEPTH_WORDS x 32 array with a 4-bit byte-write-enable, a combinational read port and a synchronous write port.
- The FSM, counter, range check and error logic stay in dmem_responder.

Test Plan:
- LATENCY=2, write 0xDEADBEEF with wmask=1111 to 0x1ECEB010, then read with rmask=1111 -> resp exactly 2 cycles after each request; rdata=0xDEADBEEF.
- Byte write wdata=0x0000AA00 with wmask=0010 to 0x1ECEB010, then read rmask=1111 -> rdata=0xDEADAAEF. Read rmask=0100 -> rdata=0x00AD0000.
- Second request asserted in the cycle after capture -> err=1; exactly one resp; the first transaction completes with correct data.
- Read 0x1ECEA000 and 0x1ECEB000+4*1024 -> resp after LATENCY, rdata=0, err=1, array unchanged.
- Assert rst one cycle after capturing a write of 0x12345678 to 0x1ECEB020 -> no resp; busy=0 and err=0 immediately. A later read returns the prior value.
- LATENCY=1, three reads issued every 2 cycles -> each resp arrives 1 cycle after its request; busy is never high on a request cycle; err=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder.
//   dmem_resp_state_t : responder FSM states
//   dmem_req_t        : captured request (address, lane masks, write data)
//   lane_mask()       : expands a 4-bit byte-lane mask to a 32-bit bit mask
package rv32i_types;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_sram_be.sv
// Word array with per-byte write enables.
//   clk   : write clock
//   we    : byte-lane write enables, lane i covers wdata[8i+7:8i]
//   addr  : word index shared by the read and write ports
//   wdata : write data, already lane-positioned
//   rdata : combinational read of the addressed word
// Contents are deliberately not reset.
module dmem_sram_be #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the pipeline data-memory port.
// Captures one request, waits LATENCY cycles, then performs the byte-enabled
// read or write and pulses dmem_resp for one cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   dmem_addr  : byte address (bits [1:0] ignored)
//   dmem_rmask : read lanes, nonzero = read request
//   dmem_wmask : write lanes, nonzero = write request
//   dmem_wdata : lane-positioned write data
//   dmem_rdata : read data, zero unless dmem_resp
//   dmem_resp  : one-cycle completion pulse
//   busy       : transaction in flight (capture through resp cycle)
//   err        : sticky error (request while busy, both masks set, out of range)
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | latency countdown
// RESP  | access performed, dmem_resp high
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1ECEB000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        busy,
  output logic        err
);

  localparam int unsigned      AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0]      SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  dmem_resp_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  dmem_req_t        req;
  logic             capture;
  logic             err_set;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off < SPAN;
  endfunction

  logic        req_present;
  logic [31:0] req_off;
  logic        req_in_range;
  logic        is_read;
  logic        is_write;
  logic [3:0]  sram_we;
  logic [31:0] mem_rdata;

  assign req_present  = (|dmem_rmask) | (|dmem_wmask);
  assign req_off      = req.addr - BASE_ADDR;
  assign req_in_range = req_off < SPAN;
  // A request with both masks set completes as a no-op.
  assign is_read      = (|req.rmask) & ~(|req.wmask);
  assign is_write     = (|req.wmask) & ~(|req.rmask);

  assign sram_we = (state == RESP && is_write && req_in_range) ? req.wmask : 4'b0000;

  dmem_sram_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .addr (req_off[AW+1:2]),
    .wdata(req.wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) req <= '{addr: dmem_addr, rmask: dmem_rmask,
                             wmask: dmem_wmask, wdata: dmem_wdata};
      if (err_set) err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_present) begin
          capture = 1'b1;
          cnt_n   = LOAD;
          state_n = (LATENCY == 1) ? RESP : WAIT;
          if (((|dmem_rmask) && (|dmem_wmask)) || !in_range(dmem_addr)) err_set = 1'b1;
        end
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        // Counter reaching zero on this edge means RESP is next.
        if (cnt <= 1) state_n = RESP;
        if (req_present) err_set = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
        if (req_present) err_set = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dmem_resp  = (state == RESP);
  assign busy       = (state != IDLE);
  assign dmem_rdata = (state == RESP && is_read && req_in_range)
                      ? (mem_rdata & lane_mask(req.rmask)) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [31:0] addr_a, wdata_a, rdata_a;
  logic [3:0]  rmask_a, wmask_a;
  logic        resp_a, busy_a, err_a;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic [3:0]  rmask_b, wmask_b;
  logic        resp_b, busy_b, err_b;

  dmem_responder #(.LATENCY(LAT_A), .DEPTH_WORDS(1024), .BASE_ADDR(32'h1ECEB000)) u_dut_a (
    .clk(clk), .rst(rst), .dmem_addr(addr_a), .dmem_rmask(rmask_a), .dmem_wmask(wmask_a),
    .dmem_wdata(wdata_a), .dmem_rdata(rdata_a), .dmem_resp(resp_a), .busy(busy_a), .err(err_a));

  dmem_responder #(.LATENCY(LAT_B), .DEPTH_WORDS(1024), .BASE_ADDR(32'h1ECEB000)) u_dut_b (
    .clk(clk), .rst(rst), .dmem_addr(addr_b), .dmem_rmask(rmask_b), .dmem_wmask(wmask_b),
    .dmem_wdata(wdata_b), .dmem_rdata(rdata_b), .dmem_resp(resp_b), .busy(busy_b), .err(err_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every resp must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_a) begin
      chk("a_resp_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("a_rdata", rdata_a, e.rdata);
      end
    end
    if (resp_b) begin
      chk("b_resp_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_resp_cycle", 32'(cyc), 32'(e.cyc));
        chk("b_rdata", rdata_b, e.rdata);
      end
    end
  end

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_timeout", 32'(busy_a), 32'd0);
  endtask

  task automatic issue_a(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, input logic [31:0] exp);
    @(posedge clk); #1;
    addr_a = a; rmask_a = rm; wmask_a = wm; wdata_a = wd;
    q_a.push_back('{cyc + LAT_A, exp});
    @(posedge clk); #1;
    rmask_a = 4'h0; wmask_a = 4'h0;
    wait_idle_a();
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    addr_a = '0; rmask_a = '0; wmask_a = '0; wdata_a = '0;
    addr_b = '0; rmask_b = '0; wmask_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", 32'(resp_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst = 1'b0;

    // Basic write/read and byte lanes
    issue_a(32'h1ECEB000, 4'h0, 4'hF, 32'h11111111, 32'h0);
    issue_a(32'h1ECEB010, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0);
    issue_a(32'h1ECEB010, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF);
    issue_a(32'h1ECEB010, 4'h0, 4'h2, 32'h0000AA00, 32'h0);
    issue_a(32'h1ECEB010, 4'hF, 4'h0, 32'h0, 32'hDEADAAEF);
    issue_a(32'h1ECEB010, 4'h4, 4'h0, 32'h0, 32'h00AD0000);
    chk("err_clean", 32'(err_a), 32'd0);

    // Request while busy: dropped, err set, first completes
    @(posedge clk); #1;
    addr_a = 32'h1ECEB010; rmask_a = 4'hF; wmask_a = 4'h0;
    q_a.push_back('{cyc + LAT_A, 32'hDEADAAEF});
    @(posedge clk); #1;
    rmask_a = 4'h0; wmask_a = 4'hF; wdata_a = 32'h0;
    @(posedge clk); #1;
    rmask_a = 4'h0; wmask_a = 4'h0;
    wait_idle_a();
    chk("err_busy_req", 32'(err_a), 32'd1);
    issue_a(32'h1ECEB010, 4'hF, 4'h0, 32'h0, 32'hDEADAAEF);
    rst_pulse();
    chk("err_cleared", 32'(err_a), 32'd0);

    // Out-of-range accesses
    issue_a(32'h1ECEA000, 4'hF, 4'h0, 32'h0, 32'h0);
    chk("err_below", 32'(err_a), 32'd1);
    rst_pulse();
    issue_a(32'h1ECEC000, 4'hF, 4'h0, 32'h0, 32'h0);
    chk("err_above", 32'(err_a), 32'd1);
    rst_pulse();
    issue_a(32'h1ECEC000, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0);
    chk("err_above_wr", 32'(err_a), 32'd1);
    rst_pulse();
    issue_a(32'h1ECEB010, 4'hF, 4'hF, 32'h0, 32'h0);
    chk("err_both_masks", 32'(err_a), 32'd1);
    issue_a(32'h1ECEB000, 4'hF, 4'h0, 32'h0, 32'h11111111);
    issue_a(32'h1ECEB010, 4'hF, 4'h0, 32'h0, 32'hDEADAAEF);

    // Reset mid-transaction (err still set from above)
    issue_a(32'h1ECEB020, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0);
    @(posedge clk); #1;
    addr_a = 32'h1ECEB020; rmask_a = 4'h0; wmask_a = 4'hF; wdata_a = 32'h12345678;
    @(posedge clk); #1;
    rmask_a = 4'h0; wmask_a = 4'h0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_err", 32'(err_a), 32'd0);
    chk("midrst_resp", 32'(resp_a), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    issue_a(32'h1ECEB020, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D);

    // LATENCY=1 instance: writes then reads at 2-cycle spacing
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b_busy_at_wr", 32'(busy_b), 32'd0);
      addr_b = 32'h1ECEB040 + 32'(4 * i); rmask_b = 4'h0; wmask_b = 4'hF;
      wdata_b = 32'hA5000000 + 32'(i);
      q_b.push_back('{cyc + LAT_B, 32'h0});
      @(posedge clk); #1;
      rmask_b = 4'h0; wmask_b = 4'h0;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b_busy_at_rd", 32'(busy_b), 32'd0);
      addr_b = 32'h1ECEB040 + 32'(4 * i); rmask_b = 4'hF; wmask_b = 4'h0;
      q_b.push_back('{cyc + LAT_B, 32'hA5000000 + 32'(i)});
      @(posedge clk); #1;
      rmask_b = 4'h0; wmask_b = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b_err", 32'(err_b), 32'd0);
    chk("a_sb_empty", 32'(q_a.size()), 32'd0);
    chk("b_sb_empty", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
